// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: E-stage forwarding,
// load-use stalls, branch flushes, memory-wait freeze with timeout, perf counters.

module hazard_fwd (
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);
   always_comb begin
      fwd = 2'b00;
      if (reg_write_m && rd_m != 5'd0 && rd_m == rs)      fwd = 2'b10;
      else if (reg_write_w && rd_w != 5'd0 && rd_w == rs) fwd = 2'b01;
   end
endmodule

module hazard_ctrl #(
   parameter int         MEM_TIMEOUT = 16,
   parameter int         CNT_W       = 16,
   parameter logic [1:0] LOAD_SRC    = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic [4:0]       rd_m,
   input  logic [4:0]       rd_w,
   input  logic [1:0]       result_src_e,
   input  logic             reg_write_m,
   input  logic             reg_write_w,
   input  logic             pc_src_e,
   input  logic             mem_access_m,
   input  logic             mem_ready,
   input  logic             cnt_clr,
   output logic [1:0]       forward_a_e,
   output logic [1:0]       forward_b_e,
   output logic             stall_f,
   output logic             stall_d,
   output logic             flush_d,
   output logic             flush_e,
   output logic             freeze,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int NUM_OPS = 2;
   localparam int WC_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

   state_t               state;
   logic [WC_W-1:0]      wait_cnt;
   logic [NUM_OPS-1:0][4:0] rs_e;
   logic [NUM_OPS-1:0][1:0] fwd;
   logic                 lw_hz, miss, run_mode, br_flush;
   logic                 stall_c, flush_d_c, flush_e_c, freeze_c;

   assign rs_e = {rs2_e, rs1_e};

   generate
      for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
         hazard_fwd u_fwd (
            .rs          (rs_e[i]),
            .rd_m        (rd_m),
            .rd_w        (rd_w),
            .reg_write_m (reg_write_m),
            .reg_write_w (reg_write_w),
            .fwd         (fwd[i])
         );
      end
   endgenerate

   assign lw_hz    = (result_src_e == LOAD_SRC) && rd_e != 5'd0 &&
                     (rd_e == rs1_d || rd_e == rs2_d);
   assign miss     = mem_access_m && !mem_ready;
   // The cycle a pending access completes behaves exactly like RUN (Mealy release).
   assign run_mode = (state == RUN) || (state == MEM_WAIT && mem_ready);

   always_comb begin
      stall_c   = 1'b0;
      flush_d_c = 1'b0;
      flush_e_c = 1'b0;
      freeze_c  = 1'b0;
      br_flush  = 1'b0;
      if (state == ERROR || (state == MEM_WAIT && !mem_ready)) begin
         stall_c  = 1'b1;
         freeze_c = 1'b1;
      end else if (run_mode) begin
         if (miss) begin
            stall_c  = 1'b1;
            freeze_c = 1'b1;
         end else if (pc_src_e) begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            br_flush  = 1'b1;
         end else if (lw_hz) begin
            stall_c   = 1'b1;
            flush_e_c = 1'b1;
         end
      end
   end

   // Combinational paths are gated so every output reads 0 while reset is held.
   assign forward_a_e = rst ? fwd[0] : 2'b00;
   assign forward_b_e = rst ? fwd[1] : 2'b00;
   assign stall_f     = rst & stall_c;
   assign stall_d     = rst & stall_c;
   assign flush_d     = rst & flush_d_c;
   assign flush_e     = rst & flush_e_c;
   assign freeze      = rst & freeze_c;
   assign mem_err     = (state == ERROR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         case (state)
            RUN: if (miss) begin
               wait_cnt <= WC_W'(1);
               state    <= (MEM_TIMEOUT == 1) ? ERROR : MEM_WAIT;
            end
            MEM_WAIT: begin
               if (mem_ready)                                   state <= RUN;
               else if (wait_cnt == WC_W'(MEM_TIMEOUT - 1))     state <= ERROR;
               else                                             wait_cnt <= wait_cnt + 1'b1;
            end
            default: state <= ERROR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_c && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
         if (br_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + randomized bench for hazard_ctrl against a cycle-level behavioural model.

module tb_hazard_ctrl;
   localparam int T   = 16;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0, rst = 1'b0;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [1:0] result_src_e;
   logic reg_write_m, reg_write_w, pc_src_e, mem_access_m, mem_ready, cnt_clr;
   logic [1:0] forward_a_e, forward_b_e;
   logic stall_f, stall_d, flush_d, flush_e, freeze, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks = 0, errors = 0;
   // Model state: consecutive memory-stall cycles, whether a wait is pending, sticky error.
   bit m_err, m_wait;
   int m_nr, m_sc, m_fc;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW), .LOAD_SRC(2'b01)) dut (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .result_src_e(result_src_e),
      .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
      .mem_access_m(mem_access_m), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .stall_f(stall_f),
      .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e), .freeze(freeze),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int fwd_of(logic [4:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 1;
      return 0;
   endfunction

   task automatic expect_ctl(output bit st, output bit fd, output bit fe, output bit fz,
                             output bit mst);
      bit lw;
      lw = (result_src_e == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      st = 0; fd = 0; fe = 0; fz = 0; mst = 0;
      if (!rst) return;
      if (m_err) begin st = 1; fz = 1; end
      else if ((m_wait && !mem_ready) || (!m_wait && mem_access_m && !mem_ready)) begin
         st = 1; fz = 1; mst = 1;
      end
      else if (pc_src_e) begin fd = 1; fe = 1; end
      else if (lw) begin st = 1; fe = 1; end
   endtask

   task automatic check_now(string tag, output bit st, output bit fd, output bit mst);
      bit fe, fz;
      expect_ctl(st, fd, fe, fz, mst);
      chk({tag, ".fwd_a"},   forward_a_e, rst ? fwd_of(rs1_e) : 0);
      chk({tag, ".fwd_b"},   forward_b_e, rst ? fwd_of(rs2_e) : 0);
      chk({tag, ".stall_f"}, stall_f, st);
      chk({tag, ".stall_d"}, stall_d, st);
      chk({tag, ".flush_d"}, flush_d, fd);
      chk({tag, ".flush_e"}, flush_e, fe);
      chk({tag, ".freeze"},  freeze, fz);
      chk({tag, ".mem_err"}, mem_err, m_err);
      chk({tag, ".stall_cnt"}, stall_cnt, m_sc);
      chk({tag, ".flush_cnt"}, flush_cnt, m_fc);
   endtask

   // Inputs are set at posedge+1; outputs checked at posedge+3; model advances at the edge.
   task automatic cyc(string tag);
      bit st, fd, mst;
      #2;
      check_now(tag, st, fd, mst);
      @(posedge clk);
      if (rst) begin
         if (!m_err) begin
            if (mst) begin
               m_nr++;
               if (m_nr >= T) m_err = 1; else m_wait = 1;
            end else begin
               m_wait = 0; m_nr = 0;
            end
         end
         if (cnt_clr) begin m_sc = 0; m_fc = 0; end
         else begin
            if (st && m_sc < SAT) m_sc++;
            if (fd && m_fc < SAT) m_fc++;
         end
      end
      #1;
   endtask

   task automatic model_reset();
      m_err = 0; m_wait = 0; m_nr = 0; m_sc = 0; m_fc = 0;
   endtask

   task automatic do_reset(string tag);
      bit st, fd, mst;
      rst = 1'b0;
      model_reset();
      #1;
      check_now(tag, st, fd, mst);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic idle();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      result_src_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0;
      mem_access_m = 0; mem_ready = 1; cnt_clr = 0;
   endtask

   initial begin
      bit st, fd, mst;
      idle();
      model_reset();
      #3;
      check_now("reset", st, fd, mst);
      @(posedge clk); #1;
      rst = 1'b1;

      // Forwarding priority
      rd_m = 5; rd_w = 5; rs1_e = 5; rs2_e = 5; reg_write_m = 1; reg_write_w = 1;
      cyc("fwd_m");
      chk("fwd_m_a", forward_a_e, 2'b10);
      reg_write_m = 0;
      cyc("fwd_w");
      chk("fwd_w_b", forward_b_e, 2'b01);
      rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0; reg_write_m = 1;
      cyc("fwd_x0");
      chk("fwd_x0_a", forward_a_e, 2'b00);

      // Load-use, then load-use masked by a taken branch
      idle(); result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
      cyc("lu");
      idle(); cyc("lu_after");
      chk("lu_stall_cnt", stall_cnt, 1);
      result_src_e = 2'b01; rd_e = 7; rs2_d = 7; pc_src_e = 1;
      cyc("lu_br");
      idle(); cyc("lu_br_after");
      chk("lu_br_flush_cnt", flush_cnt, 1);

      // Memory wait of 3 cycles with a branch presented mid-wait
      mem_access_m = 1; mem_ready = 0;
      cyc("mw1"); pc_src_e = 1; cyc("mw2"); cyc("mw3");
      mem_ready = 1; cyc("mw_rdy");
      chk("mw_rdy_freeze", freeze, 0);
      idle(); cyc("mw_post");

      // Timeout boundary: 15 not-ready cycles survive, 16 do not
      mem_access_m = 1; mem_ready = 0;
      for (int i = 0; i < T - 1; i++) cyc("to15");
      mem_ready = 1; cyc("to15_rdy");
      chk("to15_err", mem_err, 0);
      mem_ready = 0;
      for (int i = 0; i < T; i++) cyc("to16");
      mem_ready = 1; mem_access_m = 0; cyc("to16_a"); cyc("to16_b");
      chk("to16_err", mem_err, 1);
      chk("to16_freeze", freeze, 1);
      do_reset("to16_rst");

      // Reset in the middle of a memory wait
      mem_access_m = 1; mem_ready = 0;
      for (int i = 0; i < 4; i++) cyc("rmw");
      do_reset("rmw_rst");
      idle(); cyc("rmw_post");
      chk("rmw_freeze", freeze, 0);

      // Counter saturation and clear-over-increment
      result_src_e = 2'b01; rd_e = 3; rs1_d = 3;
      for (int i = 0; i < 20; i++) cyc("sat");
      chk("sat_cnt", stall_cnt, SAT);
      cnt_clr = 1; cyc("clr");
      cnt_clr = 0; cyc("clr_post");
      chk("clr_cnt", stall_cnt, 1);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
         rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
         rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
         rd_w  = 5'($urandom_range(0, 3));
         result_src_e = 2'($urandom_range(0, 3));
         reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
         pc_src_e = ($urandom_range(0, 7) == 0);
         mem_access_m = ($urandom_range(0, 3) == 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         cnt_clr = ($urandom_range(0, 31) == 0);
         if (m_err || $urandom_range(0, 63) == 0) do_reset("rnd_rst");
         else cyc("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
